// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus signals of the two-requester memory arbiter.
// err_0/err_1 exist only when MEM_ARB_WRITE_PROTECT_EN is defined.
interface mem_arbiter_if;
    logic       req_0;
    logic       req_1;
    logic       write_0;
    logic       write_1;
    logic [7:0] address_0;
    logic [7:0] address_1;
    logic [7:0] data_in_0;
    logic [7:0] data_in_1;
    logic       gnt_0;
    logic       gnt_1;
    logic       rvalid_0;
    logic       rvalid_1;
    logic [7:0] data_out_0;
    logic [7:0] data_out_1;
    logic [7:0] mem_address;
    logic [7:0] mem_data_in;
    logic       mem_write;
    logic [7:0] mem_data_out;
    logic       busy;
`ifdef MEM_ARB_WRITE_PROTECT_EN
    logic       err_0;
    logic       err_1;
`endif

    // Requesters and the memory together form the master side.
    modport master (
        output req_0, req_1, write_0, write_1,
        output address_0, address_1, data_in_0, data_in_1,
        output mem_data_out,
        input  gnt_0, gnt_1, rvalid_0, rvalid_1, data_out_0, data_out_1,
        input  mem_address, mem_data_in, mem_write, busy
`ifdef MEM_ARB_WRITE_PROTECT_EN
        , input err_0, err_1
`endif
    );

    modport slave (
        input  req_0, req_1, write_0, write_1,
        input  address_0, address_1, data_in_0, data_in_1,
        input  mem_data_out,
        output gnt_0, gnt_1, rvalid_0, rvalid_1, data_out_0, data_out_1,
        output mem_address, mem_data_in, mem_write, busy
`ifdef MEM_ARB_WRITE_PROTECT_EN
        , output err_0, err_1
`endif
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port memory: one access at a time, reads held for READ_LAT cycles.
// Optional MEM_ARB_WRITE_PROTECT_EN blocks writes to ROM and input ports and flags them on err_x.
module mem_arbiter #(
    parameter int READ_LAT   = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    localparam logic [1:0] LAST_WAIT = 2'(READ_LAT - 1);

    state_t     r_state;
    state_t     w_nextState;
    logic       r_lastGrant;
    logic       r_rdOwner;
    logic [1:0] r_waitCnt;
    logic [7:0] r_memAddress;
    logic [7:0] r_memDataIn;
    logic [7:0] r_dataOut0;
    logic [7:0] r_dataOut1;
    logic       r_rvalid0;
    logic       r_rvalid1;

    logic       w_grant0;
    logic       w_grant1;
    logic       w_grantWrite;
    logic       w_protect;
    logic       w_rdDone;
    logic [7:0] w_grantAddr;
    logic [7:0] w_grantData;

    // Address and write data default to the held bus values so an idle bus keeps its last contents.
    always_comb begin
        w_nextState  = r_state;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        w_grantAddr  = r_memAddress;
        w_grantData  = r_memDataIn;
        w_grantWrite = 1'b0;
        w_protect    = 1'b0;
        w_rdDone     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_0 && bus.req_1) begin
                    if ((FIXED_PRIO != 0) || r_lastGrant) begin
                        w_grant0 = 1'b1;
                    end else begin
                        w_grant1 = 1'b1;
                    end
                end else begin
                    w_grant0 = bus.req_0;
                    w_grant1 = bus.req_1;
                end
                if (w_grant1) begin
                    w_grantAddr  = bus.address_1;
                    w_grantWrite = bus.write_1;
                    if (bus.write_1) begin
                        w_grantData = bus.data_in_1;
                    end
                end else if (w_grant0) begin
                    w_grantAddr  = bus.address_0;
                    w_grantWrite = bus.write_0;
                    if (bus.write_0) begin
                        w_grantData = bus.data_in_0;
                    end
                end
`ifdef MEM_ARB_WRITE_PROTECT_EN
                w_protect = w_grantWrite && (!w_grantAddr[7] || (&w_grantAddr[7:4]));
`endif
                if ((w_grant0 || w_grant1) && !w_grantWrite) begin
                    w_nextState = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (r_waitCnt == LAST_WAIT) begin
                    w_rdDone    = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lastGrant  <= 1'b1;
            r_rdOwner    <= 1'b0;
            r_waitCnt    <= 2'd0;
            r_memAddress <= 8'h00;
            r_memDataIn  <= 8'h00;
            r_dataOut0   <= 8'h00;
            r_dataOut1   <= 8'h00;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_memAddress <= w_grantAddr;
            r_memDataIn  <= w_grantData;
            r_rvalid0    <= w_rdDone && !r_rdOwner;
            r_rvalid1    <= w_rdDone && r_rdOwner;
            if (w_grant0 || w_grant1) begin
                r_lastGrant <= w_grant1;
                r_rdOwner   <= w_grant1;
            end
            if (r_state == RD_WAIT) begin
                r_waitCnt <= r_waitCnt + 2'd1;
            end else begin
                r_waitCnt <= 2'd0;
            end
            // Memory data is valid in the last wait cycle; capture it for the owning requester.
            if (w_rdDone) begin
                if (r_rdOwner) begin
                    r_dataOut1 <= bus.mem_data_out;
                end else begin
                    r_dataOut0 <= bus.mem_data_out;
                end
            end
        end
    end

    assign bus.gnt_0       = w_grant0;
    assign bus.gnt_1       = w_grant1;
    assign bus.mem_address = w_grantAddr;
    assign bus.mem_data_in = w_grantData;
    assign bus.mem_write   = w_grantWrite && !w_protect;
    assign bus.busy        = (r_state == RD_WAIT);
    assign bus.rvalid_0    = r_rvalid0;
    assign bus.rvalid_1    = r_rvalid1;
    assign bus.data_out_0  = r_dataOut0;
    assign bus.data_out_1  = r_dataOut1;
`ifdef MEM_ARB_WRITE_PROTECT_EN
    assign bus.err_0       = w_protect && w_grant0;
    assign bus.err_1       = w_protect && w_grant1;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single-port computer memory (ROM 0x00–0x7F, RAM 0x80–0xDF, output ports 0xE0–0xEF, input ports 0xF0–0xFF).
- Requester 0 is the CPU; requester 1 is the DMA/program-loader.
- Sequences each access on the memory bus, holds the bus for the memory's read latency, and returns read data with a valid pulse.
- Sits between the requesters and the memory's address, data_in, write and data_out pins.

Parameters:
- READ_LAT, 1: cycles from address presented to memory data_out valid; legal range 1–3.
- FIXED_PRIO, 0: 0 = round-robin; 1 = requester 0 always wins a tie.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- req_0, req_1  in  1  access request; held, with attributes stable, until gnt.
- write_0, write_1  in  1  1 = write, 0 = read.
- address_0, address_1  in  8  target address.
- data_in_0, data_in_1  in  8  write data.
- gnt_0, gnt_1  out  1  one-cycle pulse: request issued to memory this cycle.
- rvalid_0, rvalid_1  out  1  one-cycle pulse: read data valid on data_out_x.
- data_out_0, data_out_1  out  8  read data; holds until that requester's next rvalid.
- mem_address  out  8  to memory address.
- mem_data_in  out  8  to memory data_in.
- mem_write  out  1  to memory write.
- mem_data_out  in  8  from memory data_out.
- busy  out  1  high while a read is in flight (state RD_WAIT).

Behaviour:
- Reset values:
  - State IDLE; gnt_x, rvalid_x, mem_write and busy at 0.
  - mem_address, mem_data_in and data_out_x at 0x00.
  - last_grant = 1, so requester 0 wins the first tie.
- Two-state FSM.
- IDLE:
  - No req: bus idle. mem_write = 0; mem_address and mem_data_in hold their last values.
  - One req: grant it.
  - Both req: FIXED_PRIO=1 → requester 0. FIXED_PRIO=0 → requester ≠ last_grant; last_grant updates on every grant.
- Grant cycle N (combinational in IDLE):
  - gnt_x = 1; mem_address = address_x.
  - Write: mem_write = 1, mem_data_in = data_in_x; stay IDLE. Back-to-back writes allowed, one per cycle.
  - Read: mem_write = 0; go to RD_WAIT.
- RD_WAIT:
  - mem_address held at the granted address; mem_write = 0; no grants issued.
  - Remains for READ_LAT cycles (N+1..N+READ_LAT).
  - At the end of cycle N+READ_LAT: capture mem_data_out into data_out_x and return to IDLE.
- Read completion:
  - rvalid_x pulses in cycle N+READ_LAT+1.
  - A new grant may issue in that same cycle.
  - Read latency, gnt to rvalid, is READ_LAT+1 cycles.
- Request lifetime:
  - req dropped before gnt: withdrawn, no side effects.
  - req still high the cycle after gnt: treated as a new request and re-arbitrated.
  - A request arriving during RD_WAIT waits; it is never lost.
- Ordering: at most one transaction outstanding; responses strictly in grant order.
- Reset mid-read:
  - FSM → IDLE; the pending read is discarded and no rvalid is issued.
  - data_out_x cleared to 0x00.
- Address range: no address decoding by default; all 256 addresses are forwarded unchanged.

Optional Feature:
- Macro MEM_ARB_WRITE_PROTECT_EN.
- When defined:
  - Adds outputs err_0 and err_1 (1 bit each, reset 0).
  - A granted write to 0x00–0x7F (ROM) or 0xF0–0xFF (input ports) still pulses gnt_x, but mem_write stays 0.
  - err_x pulses in the same cycle; reads are unaffected.
- When undefined: err_x ports are absent and all writes are forwarded.

Test Plan:
- Single write, then read: req_0 write 0x80 ← 0x5A; then req_0 read 0x80 → gnt_0 cycle N, rvalid_0 at N+2 (READ_LAT=1), data_out_0 = 0x5A.
- Tie, round-robin: req_0 and req_1 both write continuously from reset → grants alternate 0,1,0,1; the first mem_write cycle carries address_0.
- FIXED_PRIO=1 tie: both requesting → gnt_0 every cycle, gnt_1 never while req_0 held; gnt_1 once req_0 drops.
- Read blocking: req_0 read 0xF0 (port_in_00 = 0xAA) with req_1 write 0xE0 ← 0xF1 raised the following cycle:
  - rvalid_0 with 0xAA.
  - gnt_1 no earlier than the rvalid_0 cycle.
  - port_out_00 = 0xF1 afterwards.
- Reset mid-read: READ_LAT=3, reset asserted in cycle N+2 → no rvalid_0, data_out_0 = 0x00, busy = 0, next request granted normally.
- MEM_ARB_WRITE_PROTECT_EN defined: write 0x05 ← 0x77 → gnt_x and err_x pulse, mem_write stays 0; ROM read of 0x05 returns its original contents.
